// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle WIDTH-bit adder that processes DIGIT bits per
// clock, least-significant digit first, through one shared DIGIT-bit carry slice.
// Valid/ready handshake on input and output; reports carry-out and signed overflow.
// Optional feature: define DSA_SUB_EN to add the 'sub' port (a + ~b + cin).
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef DSA_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              carry_q, carry_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;
   logic              ovf_q, ovf_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;

   logic [DIGIT-1:0]  a_dig;
   logic [DIGIT-1:0]  b_dig;
   logic [DIGIT:0]    dig_full;
   logic              msb_cin;
   logic              last_dig;
   logic [WIDTH-1:0]  a_shift;
   logic [WIDTH-1:0]  b_shift;
   logic [WIDTH-1:0]  sum_shift;

   // Operands are consumed from the bottom by shifting right one digit per cycle;
   // each new sum digit enters at the top, so after N digits it sits in place.
   assign a_dig    = a_q[DIGIT-1:0];
   assign b_dig    = b_q[DIGIT-1:0];
   assign dig_full = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
   assign msb_cin  = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_full[DIGIT-1];
   assign last_dig = (cnt_q == CW'(N - 1));

   if (DIGIT < WIDTH) begin : g_shift
      assign a_shift   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
      assign b_shift   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
      assign sum_shift = {dig_full[DIGIT-1:0], sum_q[WIDTH-1:DIGIT]};
   end else begin : g_whole
      assign a_shift   = '0;
      assign b_shift   = '0;
      assign sum_shift = dig_full[DIGIT-1:0];
   end

   // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = a;
`ifdef DSA_SUB_EN
               b_d        = sub ? ~b : b;
`else
               b_d        = b;
`endif
               carry_d    = cin;
               cnt_d      = '0;
               sum_d      = '0;
               cout_d     = 1'b0;
               ovf_d      = 1'b0;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            a_d     = a_shift;
            b_d     = b_shift;
            sum_d   = sum_shift;
            carry_d = dig_full[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            if (last_dig) begin
               cout_d      = dig_full[DIGIT];
               ovf_d       = msb_cin ^ dig_full[DIGIT];
               cnt_d       = '0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, least-significant digit first, with one shared DIGIT-bit carry-chain slice. Successor to the single-bit half/full adder cells for datapaths where area matters more than latency. Valid/ready on both sides, so it can sit between register stages of the arithmetic pipeline. Reports carry-out and signed overflow.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT digit cycles per operation.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in into bit 0.
- sub  input  1  only when DSA_SUB_EN is defined; selects subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, low WIDTH bits.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture a, b, cin (and sub), clear digit counter and sum register, go RUN.
- RUN: each cycle, digit i (bits i·DIGIT+DIGIT-1 : i·DIGIT) = A_i + B_i + carry. Result goes into sum[digit i]. Carry register is updated. Counter increments. After digit N-1, latch cout and overflow and go DONE.
- DONE: out_valid=1. sum, cout and overflow are held stable. On out_valid&&out_ready go IDLE.
- in_valid is ignored outside IDLE. Input changes after capture have no effect.
- Counter width is max(1, clog2(N)). N=1 is legal: RUN lasts one cycle.
- Arithmetic is modulo 2^WIDTH. cout = bit WIDTH of the full sum.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, state IDLE, counter 0, carry 0.
- Accept at edge t0. Digits are computed on edges t1..tN. out_valid=1 from after edge tN.
- Result handshake at edge tR: out_valid=0 and in_ready=1 from after tR. There is no same-cycle bypass into a new accept.
- Maximum throughput: one operation per N+2 cycles when out_ready is held at 1.
- out_ready low in DONE: stall indefinitely with outputs stable and in_ready=0.
- rst_n low at any point, including mid-RUN or in DONE, aborts the operation immediately. All outputs return to reset values asynchronously. No result is produced for the aborted operand.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- DSA_SUB_EN defined:
  - Adds the sub port, captured at accept.
  - sub=1 computes a − b − (1−cin), implemented as a + ~b + cin.
  - With cin=1 this gives plain a−b. cout=1 means no borrow.
  - overflow uses the same MSB rule.
- DSA_SUB_EN undefined: no sub port; addition only.

## Test plan
- WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0; out_valid rises exactly 4 cycles after accept.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1; a=0x1234, b=0x1111, cin=1 -> sum=0x2346, cout=0, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout/overflow stable, in_ready=0; a new in_valid during the stall is not accepted. Release -> in_ready=1 one cycle later.
- Reset mid-RUN: drop rst_n after 2 digits -> all outputs at reset values immediately. After release, a new op 0x0003+0x0004 gives 0x0007 with normal latency.
- DSA_SUB_EN: sub=1, a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0. sub=1, a=0x8000, b=0x0001, cin=1 -> sum=0x7FFF, overflow=1.
- WIDTH=8, DIGIT=1 and WIDTH=8, DIGIT=8: 1000 random operands vs a behavioural model -> all results match; latency is 8 and 1 cycles respectively.
